// File: rtl/jk_command_sequencer.sv
// Queued JK command driver: buffers {op,count} commands, drives registered J/K for count+1
// cycles each, and tracks the expected flip-flop state against the Q fed back.
module jk_command_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             J,
  output logic             K,
  input  logic             q_in,
  output logic             expected_q,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t             state;
  logic [CNT_W+1:0]   mem [DEPTH];
  logic [CNT_W+1:0]   head;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        occ;
  logic [CNT_W-1:0]   remaining;
  logic               push;
  logic               pop;

  assign cmd_ready = (occ != FULL);
  assign push      = cmd_valid && cmd_ready;
  // Pop decision uses pre-edge occupancy, so a same-edge push is never popped.
  assign pop       = (occ != '0) && ((state == IDLE) || (remaining == '0));
  assign head      = mem[rd_ptr];
  assign busy      = (state == DRIVE) || (occ != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_count};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      J         <= 1'b0;
      K         <= 1'b0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            {J, K}    <= head[CNT_W+1:CNT_W];
            remaining <= head[CNT_W-1:0];
            state     <= DRIVE;
          end else begin
            J <= 1'b0;
            K <= 1'b0;
          end
        end
        DRIVE: begin
          if (remaining != '0) begin
            remaining <= remaining - 1'b1;
          end else if (pop) begin
            {J, K}    <= head[CNT_W+1:CNT_W];
            remaining <= head[CNT_W-1:0];
          end else begin
            J     <= 1'b0;
            K     <= 1'b0;
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Model uses the same J/K the flip-flop master samples; q_in reflects the previous prediction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expected_q <= 1'b0;
      mismatch   <= 1'b0;
    end else begin
      case ({J, K})
        2'b00:   expected_q <= expected_q;
        2'b01:   expected_q <= 1'b0;
        2'b10:   expected_q <= 1'b1;
        default: expected_q <= ~expected_q;
      endcase
      mismatch <= mismatch | (q_in != expected_q);
    end
  end

endmodule

// File: tb/tb_jk_command_sequencer.sv
// Randomized and directed bench for jk_command_sequencer with a queue-based reference
// model and a behavioural master-slave JK flip-flop providing q_in.
module tb_jk_command_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             J, K, q_in, expected_q, busy, done, mismatch;

  jk_command_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .J(J), .K(K), .q_in(q_in),
    .expected_q(expected_q), .busy(busy), .done(done), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  // Behavioural master-slave flip-flop fed by the DUT.
  logic ff_master, ff_slave;
  logic force_en = 1'b0;
  logic force_val = 1'b0;
  always @(posedge clk or posedge reset) begin
    if (reset) ff_master <= 1'b0;
    else case ({J, K})
      2'b01:   ff_master <= 1'b0;
      2'b10:   ff_master <= 1'b1;
      2'b11:   ff_master <= ~ff_master;
      default: ff_master <= ff_master;
    endcase
  end
  always @(negedge clk or posedge reset) begin
    if (reset) ff_slave <= 1'b0;
    else       ff_slave <= ff_master;
  end
  assign q_in = force_en ? force_val : ff_slave;

  typedef struct {
    logic [1:0]       op;
    logic [CNT_W-1:0] cnt;
  } cmd_t;

  cmd_t        mq[$];
  cmd_t        offer[$];
  logic [1:0]  m_jk;
  int unsigned m_left;
  logic        m_q, m_done, m_mis;
  bit          held;
  int unsigned gap_pct;
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic jk_next(input logic q, input logic [1:0] jk);
    case (jk)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  task automatic model_clear();
    mq.delete();
    offer.delete();
    m_jk = '0; m_left = 0; m_q = 1'b0; m_done = 1'b0; m_mis = 1'b0;
    held = 1'b0;
  endtask

  task automatic step();
    bit   acc;
    logic qin_s, q_pre;
    cmd_t c;
    @(negedge clk);
    if (!held) begin
      if (offer.size() > 0 && $urandom_range(99) >= gap_pct) begin
        cmd_valid = 1'b1; cmd_op = offer[0].op; cmd_count = offer[0].cnt;
      end else begin
        cmd_valid = 1'b0;
      end
    end
    #1;
    acc   = cmd_valid && (mq.size() < DEPTH);
    qin_s = q_in;
    check_eq("ready", {31'b0, cmd_ready}, {31'b0, mq.size() < DEPTH});
    @(posedge clk);
    q_pre = m_q;
    m_q = jk_next(m_q, m_jk);
    if (qin_s !== q_pre) m_mis = 1'b1;
    m_done = 1'b0;
    if (m_left > 1) begin
      m_left--;
    end else if (mq.size() > 0) begin
      c = mq.pop_front();
      m_jk = c.op;
      m_left = int'(c.cnt) + 1;
    end else begin
      m_done = (m_left == 1);
      m_jk = '0;
      m_left = 0;
    end
    if (acc) begin
      mq.push_back(offer.pop_front());
      held = 1'b0;
    end else begin
      held = cmd_valid;
    end
    #1;
    check_eq("jk",       {30'b0, J, K},       {30'b0, m_jk});
    check_eq("exp_q",    {31'b0, expected_q}, {31'b0, m_q});
    check_eq("done",     {31'b0, done},       {31'b0, m_done});
    check_eq("busy",     {31'b0, busy},       {31'b0, (m_left > 0) || (mq.size() > 0)});
    check_eq("mismatch", {31'b0, mismatch},   {31'b0, m_mis});
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((offer.size() > 0 || m_left > 0 || mq.size() > 0) && n < max_cycles) begin
      step();
      n++;
    end
    check_eq("drain_timeout", {31'b0, n >= max_cycles}, 32'd0);
    repeat (2) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    cmd_valid = 1'b0;
    force_en = 1'b0;
    #1;
    check_eq("rst_jk",    {30'b0, J, K},       32'd0);
    check_eq("rst_busy",  {31'b0, busy},       32'd0);
    check_eq("rst_expq",  {31'b0, expected_q}, 32'd0);
    check_eq("rst_ready", {31'b0, cmd_ready},  32'd1);
    check_eq("rst_mis",   {31'b0, mismatch},   32'd0);
    check_eq("rst_done",  {31'b0, done},       32'd0);
    model_clear();
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_clear();
    gap_pct = 0;
    do_reset();

    // Single set
    offer.push_back('{2'b10, 4'd0});
    drain(50);
    check_eq("single_q", {31'b0, q_in}, 32'd1);

    // Toggle run from a cleared state
    do_reset();
    offer.push_back('{2'b11, 4'd3});
    drain(50);
    check_eq("toggle_end", {31'b0, expected_q}, 32'd0);

    // Back-pressure: long first command, five more behind it
    offer.push_back('{2'b10, 4'd15});
    for (int unsigned i = 0; i < 5; i++)
      offer.push_back('{2'(i), 4'(i)});
    drain(200);

    // Back-to-back with no hold gap
    offer.push_back('{2'b10, 4'd1});
    offer.push_back('{2'b01, 4'd0});
    drain(50);

    // Forced q_in disagreement, sticky until reset
    do_reset();
    force_en = 1'b1; force_val = 1'b0;
    offer.push_back('{2'b10, 4'd2});
    drain(50);
    force_en = 1'b0;
    repeat (3) step();
    check_eq("mis_sticky", {31'b0, mismatch}, 32'd1);
    do_reset();

    // Reset while driving with commands queued
    offer.push_back('{2'b11, 4'd7});
    offer.push_back('{2'b01, 4'd2});
    offer.push_back('{2'b10, 4'd3});
    repeat (5) step();
    do_reset();
    repeat (5) step();

    // Randomized traffic
    gap_pct = 40;
    for (int unsigned i = 0; i < 200; i++)
      offer.push_back('{2'($urandom_range(3)),
                       ($urandom_range(9) == 0) ? 4'd15 : 4'($urandom_range(4))});
    drain(5000);
    gap_pct = 0;
    for (int unsigned i = 0; i < 40; i++)
      offer.push_back('{2'($urandom_range(3)), 4'($urandom_range(2))});
    drain(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_command_sequencer.md
# jk_command_sequencer

Upstream driver for the master-slave JK flip-flop. Accepts hold/reset/set/toggle commands over a valid/ready handshake and buffers them in a small FIFO. Each command drives registered J/K outputs for a programmed number of clock cycles. A reference model predicts the flip-flop output and flags any disagreement with the Q fed back from the flip-flop.

## Interface
- DEPTH, 4, command FIFO entries; must be a power of 2 and ≥2
- CNT_W, 4, width of repeat count; a command drives for cmd_count+1 cycles (1..2^CNT_W)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd_op  in  2  {J,K} code: 00 hold, 01 reset, 10 set, 11 toggle
- cmd_count  in  CNT_W  extra drive cycles beyond the first
- J  out  1  registered J to flip-flop
- K  out  1  registered K to flip-flop
- q_in  in  1  Q output of the flip-flop
- expected_q  out  1  model prediction of flip-flop master state
- busy  out  1  FSM in DRIVE or FIFO non-empty
- done  out  1  one-cycle pulse when the last queued command finishes
- mismatch  out  1  sticky error; q_in disagreed with the model

## Operation
- Push: cmd_valid && cmd_ready at a rising edge writes {cmd_op, cmd_count} to the FIFO.
  - cmd_valid with cmd_ready low is ignored; the source holds the command.
- FIFO: circular buffer with read/write pointers and an occupancy counter of $clog2(DEPTH)+1 bits.
  - Push and pop on the same edge leave occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, DRIVE.
  - IDLE, FIFO non-empty: pop, load op into J/K, load remaining = count, go to DRIVE.
  - IDLE, FIFO empty: J=K=0, stay.
  - DRIVE, remaining > 0: decrement remaining, hold J/K.
  - DRIVE, remaining == 0, FIFO non-empty: pop the next command and load it on this edge. Back-to-back commands have no hold gap; stay in DRIVE.
  - DRIVE, remaining == 0, FIFO empty: J=K=0, go to IDLE, assert done for the next cycle.
- A command pushed into an empty FIFO in the same edge that DRIVE finishes is not visible to that edge's pop. The FSM goes to IDLE, then pops it on the next edge.
- Model: every rising edge, expected_q takes the JK next-state of itself using the current J/K register values (the same values the flip-flop master samples):
  - 00 hold; 01 → 0; 10 → 1; 11 → invert.
- Check: every rising edge out of reset, compare q_in with the pre-update expected_q.
  - The slave copies the master on the preceding falling edge, so the two must match.
  - Any inequality sets mismatch. It stays set until reset.
- cmd_op = 00 with any count is legal. It drives hold for count+1 cycles.

## Timing
- Reset values: J=0, K=0, expected_q=0, mismatch=0, done=0, busy=0, cmd_ready=1. FIFO is empty; state is IDLE.
- A command accepted at edge t into an empty, idle block:
  - popped at edge t+1; J/K valid after t+1.
  - sampled by the flip-flop master at t+2; q_in reflects it after the falling edge in cycle t+2.
- A command occupies J/K for exactly cmd_count+1 cycles.
- done is high in the first cycle in which J/K have returned to 00.
- cmd_ready is combinational from occupancy; it is low only when occupancy == DEPTH.
- Reset asserted mid-DRIVE:
  - J/K go to 0 immediately (asynchronously).
  - FIFO contents are discarded, the model and mismatch clear, and no done pulse is produced.
- mismatch updates at the edge where the disagreement is sampled, with no further delay.

## Test plan
- Single set: push op=10, count=0 into an idle block → J=1,K=0 for exactly 1 cycle. expected_q becomes 1, done pulses once, q_in from the real flip-flop is 1 afterwards, mismatch stays 0.
- Toggle run: push op=11, count=3 → J=K=1 for 4 cycles. expected_q sequence is 1,0,1,0, ending at 0, and matches q_in each cycle.
- Back-pressure with DEPTH=4: push 5 commands while the first drives op=10, count=15.
  - cmd_ready drops after occupancy reaches 4 and the 5th command is held.
  - It is accepted after the next pop; no command is lost or duplicated.
- Back-to-back: queue op=10/count=1 then op=01/count=0 → J/K reads 10,10,01 then 00, with no 00 gap between commands. done pulses once, after the last command.
- Mismatch: drive op=10, count=2 with q_in forced to 0 instead of the flip-flop → mismatch rises at the first edge where expected_q=1 is compared. It stays 1 after the force is released, until reset.
- Reset mid-drive: assert reset during op=11, count=7 with 2 commands queued → J=K=0, busy=0, expected_q=0 and cmd_ready=1 immediately. After release the block stays IDLE with no output activity.
